irq_encoder8to3: RTL and testbench
==================================

IRQ_ENCODER8TO3 -- requirements
Module: irq_encoder8to3

Interface
REQ-001 SHALL have parameter HIGH_FIRST, default 1; 1 = line 7 highest priority, 0 = line 0 highest.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port e1  input  1  active-high enable.
REQ-005 SHALL have ports ne2, ne3  input  1 each  active-low enables; the block is enabled when e1 & ~ne2 & ~ne3.
REQ-006 SHALL have port req_n  input  8  active-low request lines, one per source.
REQ-007 SHALL have port ack  input  1  consumer acknowledge of the presented code.
REQ-008 SHALL have port valid  output  1  the code is presented and stable.
REQ-009 SHALL have port code  output  3  index of the presented request.
REQ-010 SHALL have port gs_n  output  1  active-low group signal, low when any pending bit is set.
REQ-011 SHALL have port pending  output  8  pending request bits, registered.

Function
REQ-012 SHALL register req_n into req_q every cycle; an assertion edge on line i is req_q[i]=1 and req_n[i]=0.
REQ-013 SHALL set pending[i] on the clock edge at which an assertion edge on line i is detected, regardless of enable.
REQ-014 SHALL NOT re-set pending[i] while req_n[i] is held low; the line must return high first.
REQ-015 SHALL implement FSM states IDLE and PRESENT.
REQ-016 In IDLE, when enabled and pending != 0, SHALL latch code = highest-priority pending index per HIGH_FIRST, assert valid, and go to PRESENT on the next edge.
REQ-017 In PRESENT, SHALL hold code and valid stable until ack=1, even if enable drops or higher-priority bits become pending.
REQ-018 In PRESENT with ack=1, SHALL clear pending[code], deassert valid, and return to IDLE on the same edge.
REQ-019 After an ack, SHALL spend at least one cycle in IDLE before presenting again, so valid has a minimum one-cycle low gap.
REQ-020 SHALL ignore ack while valid=0.
REQ-021 If an assertion edge on line code coincides with its ack-clear, set SHALL win and pending[code] remains 1.
REQ-022 Latency: req_n[i] falling before edge n sets pending at edge n; valid rises at edge n+1 if the block is idle and enabled.
REQ-023 gs_n SHALL be ~|pending, a combinational function of registered pending.
REQ-024 code SHALL read 3'b000 whenever valid=0.

Reset
REQ-025 On reset=1 at a clock edge: valid=0, code=0, pending=0, FSM=IDLE, req_q=8'hFF; gs_n=1 follows.
REQ-026 Reset mid-PRESENT SHALL drop valid with no ack required; a line held low through reset SHALL register as a new assertion on the first cycle after reset.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=1'b0, PRESENT=1'b1) and the constant NUM_LINES=8.
REQ-028 The priority selection SHALL be a combinational sub-module prio_sel8 (inputs pending and HIGH_FIRST; outputs idx[2:0] and any).

Verification
REQ-029 Reset, then req_n=8'hFF with enabled=1 -> valid=0, gs_n=1, pending=0 for 10 cycles.
REQ-030 req_n[5] pulsed low for 1 cycle, HIGH_FIRST=1 -> pending=8'h20 next edge, valid=1 with code=5 one edge later; ack=1 for 1 cycle -> pending=0, valid=0.
REQ-031 Lines 2 and 6 asserted on the same edge -> code=6 first; after ack and a 1-cycle gap, code=2. With HIGH_FIRST=0, the order is 2 then 6.
REQ-032 While code=3 is presented, assert line 7 and set ne2=1 -> code stays 3 until ack; no output changes before ack.
REQ-033 Hold req_n[4] low for 20 cycles and ack once -> exactly one presentation of code 4; assert a new edge on line 4 in the ack cycle -> pending[4] stays 1 and code 4 is presented again.
REQ-034 Reset while valid=1 with req_n[1] held low -> valid=0 and pending=0 after the reset edge; after reset releases, pending[1]=1 and code=1 is presented.

Source files
------------

// File: rtl/irq_encoder8to3_pkg.sv
// Shared definitions for the 8-to-3 interrupt priority encoder.
//   NUM_LINES  : number of request lines
//   CODE_W     : width of the presented code
//   state_e    : presentation FSM state encoding
//   line_mask  : one-hot mask for a line index
package irq_encoder8to3_pkg;

  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned CODE_W    = $clog2(NUM_LINES);

  typedef enum logic {
    StIdle    = 1'b0,
    StPresent = 1'b1
  } state_e;

  function automatic logic [NUM_LINES-1:0] line_mask(input logic [CODE_W-1:0] idx);
    return NUM_LINES'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_sel8.sv
// Combinational priority selector over the pending request bits.
//   HIGH_FIRST : 1 = highest index wins, 0 = lowest index wins
//   pending_i  : pending request bits
//   idx_o      : index of the winning bit (0 when none set)
//   any_o      : at least one bit is set
module prio_sel8
  import irq_encoder8to3_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [NUM_LINES-1:0] pending_i,
  output logic [CODE_W-1:0]    idx_o,
  output logic                 any_o
);

  // Later assignments overwrite earlier ones, so scan towards the winning end.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (HIGH_FIRST) begin
        if (pending_i[i]) idx_o = CODE_W'(i);
      end else begin
        if (pending_i[NUM_LINES-1-i]) idx_o = CODE_W'(NUM_LINES-1-i);
      end
    end
  end

  assign any_o = |pending_i;

endmodule

// File: rtl/irq_encoder8to3.sv
// Edge-detecting interrupt encoder with a valid/ack presentation handshake.
//   clk, reset     : clock and synchronous active-high reset
//   e1, ne2, ne3   : enables; active when e1 & ~ne2 & ~ne3
//   req_n          : active-low request lines; falling edges latch into pending
//   ack            : consumer accepts the presented code
//   valid, code    : presented request index, held until ack
//   gs_n           : low when any pending bit is set
//   pending        : registered pending request bits
module irq_encoder8to3
  import irq_encoder8to3_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 e1,
  input  logic                 ne2,
  input  logic                 ne3,
  input  logic [NUM_LINES-1:0] req_n,
  input  logic                 ack,
  output logic                 valid,
  output logic [CODE_W-1:0]    code,
  output logic                 gs_n,
  output logic [NUM_LINES-1:0] pending
);

  state_e                 state_q, state_d;
  logic [CODE_W-1:0]      code_q, code_d;
  logic [NUM_LINES-1:0]   req_q;
  logic [NUM_LINES-1:0]   pending_q, pending_d;
  logic [NUM_LINES-1:0]   assert_edge;
  logic [NUM_LINES-1:0]   clr_mask;
  logic [CODE_W-1:0]      sel_idx;
  logic                   sel_any;
  logic                   enabled;
  logic                   ack_take;

  prio_sel8 #(
    .HIGH_FIRST(HIGH_FIRST)
  ) u_prio_sel8 (
    .pending_i(pending_q),
    .idx_o    (sel_idx),
    .any_o    (sel_any)
  );

  assign enabled     = e1 & ~ne2 & ~ne3;
  assign assert_edge = req_q & ~req_n;
  assign ack_take    = (state_q == StPresent) & ack;
  assign clr_mask    = ack_take ? line_mask(code_q) : '0;
  // Clear first, then set: a fresh edge on the acked line keeps it pending.
  assign pending_d   = (pending_q & ~clr_mask) | assert_edge;

  // State register. req_q resets to all-ones so a line held low through
  // reset is seen as a new assertion once reset releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      code_q    <= '0;
      pending_q <= '0;
      req_q     <= '1;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
      req_q     <= req_n;
    end
  end

  // Next-state logic. Leaving PRESENT always lands in IDLE for at least one
  // cycle, which gives valid its minimum low gap.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (enabled && sel_any) begin
          state_d = StPresent;
          code_d  = sel_idx;
        end
      end
      StPresent: begin
        if (ack) begin
          state_d = StIdle;
          code_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
        code_d  = '0;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    valid   = (state_q == StPresent);
    code    = valid ? code_q : '0;
    gs_n    = ~|pending_q;
    pending = pending_q;
  end

endmodule

// File: tb/tb_irq_encoder8to3.sv
module tb_irq_encoder8to3;

  logic       clk;
  logic       reset;
  logic       e1, ne2, ne3;
  logic [7:0] req_n;
  logic       ack;

  logic       valid_hi, valid_lo;
  logic [2:0] code_hi, code_lo;
  logic       gs_n_hi, gs_n_lo;
  logic [7:0] pending_hi, pending_lo;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: per-line pending flags and the presented line (-1 = none).
  // Index 0 tracks the HIGH_FIRST=1 instance, index 1 the HIGH_FIRST=0 one.
  bit m_prev [8];
  bit m_pend [2][8];
  int m_pres [2];

  irq_encoder8to3 #(.HIGH_FIRST(1'b1)) dut_hi (
    .clk    (clk),
    .reset  (reset),
    .e1     (e1),
    .ne2    (ne2),
    .ne3    (ne3),
    .req_n  (req_n),
    .ack    (ack),
    .valid  (valid_hi),
    .code   (code_hi),
    .gs_n   (gs_n_hi),
    .pending(pending_hi)
  );

  irq_encoder8to3 #(.HIGH_FIRST(1'b0)) dut_lo (
    .clk    (clk),
    .reset  (reset),
    .e1     (e1),
    .ne2    (ne2),
    .ne3    (ne3),
    .req_n  (req_n),
    .ack    (ack),
    .valid  (valid_lo),
    .code   (code_lo),
    .gs_n   (gs_n_lo),
    .pending(pending_lo)
  );

  wire [12:0] obs_hi = {valid_hi, code_hi, gs_n_hi, pending_hi};
  wire [12:0] obs_lo = {valid_lo, code_lo, gs_n_lo, pending_lo};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance the model by one clock edge using the inputs that will be seen there.
  task automatic model_step();
    bit en;
    int sel;
    en = e1 && !ne2 && !ne3;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_prev[i] = 1'b1;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 8; i++) m_pend[k][i] = 1'b0;
        m_pres[k] = -1;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_pres[k] >= 0) begin
          if (ack) begin
            m_pend[k][m_pres[k]] = 1'b0;
            m_pres[k] = -1;
          end
        end else if (en) begin
          sel = -1;
          for (int i = 0; i < 8; i++) begin
            if (m_pend[k][i]) begin
              if (k == 0) sel = i;
              else if (sel < 0) sel = i;
            end
          end
          m_pres[k] = sel;
        end
        for (int i = 0; i < 8; i++) begin
          if (m_prev[i] && !req_n[i]) m_pend[k][i] = 1'b1;
        end
      end
      for (int i = 0; i < 8; i++) m_prev[i] = req_n[i];
    end
  endtask

  function automatic logic [12:0] exp_obs(input int k);
    logic [7:0] p;
    logic       v;
    logic [2:0] c;
    for (int i = 0; i < 8; i++) p[i] = m_pend[k][i];
    v = (m_pres[k] >= 0);
    c = v ? 3'(m_pres[k]) : 3'd0;
    return {v, c, (p == 8'h00), p};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; e1 = 1'b1; ne2 = 1'b0; ne3 = 1'b0; req_n = 8'hFF; ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (obs_hi !== 13'b0_000_1_00000000)
        $display("FAIL reset_idle_hi cyc=%0d got=%h want=%h", c, obs_hi, 13'b0_000_1_00000000);
      else n_pass++;
      n_checks++;
      if (obs_lo !== 13'b0_000_1_00000000)
        $display("FAIL reset_idle_lo cyc=%0d got=%h want=%h", c, obs_lo, 13'b0_000_1_00000000);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    req_n = 8'hDF;
    tick();
    n_checks++;
    if (obs_hi !== {1'b0, 3'd0, 1'b0, 8'h20})
      $display("FAIL single_pend got=%h want=%h", obs_hi, {1'b0, 3'd0, 1'b0, 8'h20});
    else n_pass++;
    req_n = 8'hFF;
    tick();
    n_checks++;
    if (obs_hi !== {1'b1, 3'd5, 1'b0, 8'h20})
      $display("FAIL single_present got=%h want=%h", obs_hi, {1'b1, 3'd5, 1'b0, 8'h20});
    else n_pass++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (obs_hi !== {1'b0, 3'd0, 1'b1, 8'h00})
      $display("FAIL single_ack got=%h want=%h", obs_hi, {1'b0, 3'd0, 1'b1, 8'h00});
    else n_pass++;
  endtask

  task automatic test_two_lines();
    req_n = ~8'h44;
    tick();
    req_n = 8'hFF;
    tick();
    n_checks++;
    if (obs_hi !== {1'b1, 3'd6, 1'b0, 8'h44})
      $display("FAIL two_first_hi got=%h want=%h", obs_hi, {1'b1, 3'd6, 1'b0, 8'h44});
    else n_pass++;
    n_checks++;
    if (obs_lo !== {1'b1, 3'd2, 1'b0, 8'h44})
      $display("FAIL two_first_lo got=%h want=%h", obs_lo, {1'b1, 3'd2, 1'b0, 8'h44});
    else n_pass++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (obs_hi !== {1'b0, 3'd0, 1'b0, 8'h04})
      $display("FAIL two_gap_hi got=%h want=%h", obs_hi, {1'b0, 3'd0, 1'b0, 8'h04});
    else n_pass++;
    n_checks++;
    if (obs_lo !== {1'b0, 3'd0, 1'b0, 8'h40})
      $display("FAIL two_gap_lo got=%h want=%h", obs_lo, {1'b0, 3'd0, 1'b0, 8'h40});
    else n_pass++;
    tick();
    n_checks++;
    if (obs_hi !== {1'b1, 3'd2, 1'b0, 8'h04})
      $display("FAIL two_second_hi got=%h want=%h", obs_hi, {1'b1, 3'd2, 1'b0, 8'h04});
    else n_pass++;
    n_checks++;
    if (obs_lo !== {1'b1, 3'd6, 1'b0, 8'h40})
      $display("FAIL two_second_lo got=%h want=%h", obs_lo, {1'b1, 3'd6, 1'b0, 8'h40});
    else n_pass++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_hold_stable();
    req_n = 8'hF7;
    tick();
    req_n = 8'hFF;
    tick();
    req_n = 8'h7F;
    ne2   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      req_n = 8'hFF;
      n_checks++;
      if (obs_hi !== {1'b1, 3'd3, 1'b0, 8'h88})
        $display("FAIL hold_stable cyc=%0d got=%h want=%h", c, obs_hi, {1'b1, 3'd3, 1'b0, 8'h88});
      else n_pass++;
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    n_checks++;
    if (obs_hi !== {1'b0, 3'd0, 1'b0, 8'h80})
      $display("FAIL hold_disabled got=%h want=%h", obs_hi, {1'b0, 3'd0, 1'b0, 8'h80});
    else n_pass++;
    ne2 = 1'b0;
    tick();
    n_checks++;
    if (obs_hi !== {1'b1, 3'd7, 1'b0, 8'h80})
      $display("FAIL hold_next got=%h want=%h", obs_hi, {1'b1, 3'd7, 1'b0, 8'h80});
    else n_pass++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_held_low();
    int presentations;
    logic prev_valid;
    presentations = 0;
    prev_valid    = 1'b0;
    req_n = 8'hEF;
    for (int c = 0; c < 20; c++) begin
      ack = (c == 5);
      tick();
      if (valid_hi && !prev_valid) presentations++;
      prev_valid = valid_hi;
    end
    ack = 1'b0;
    n_checks++;
    if (presentations != 1)
      $display("FAIL held_low_count got=%0d want=1", presentations);
    else n_pass++;
    n_checks++;
    if (obs_hi !== {1'b0, 3'd0, 1'b1, 8'h00})
      $display("FAIL held_low_idle got=%h want=%h", obs_hi, {1'b0, 3'd0, 1'b1, 8'h00});
    else n_pass++;
    req_n = 8'hFF;
    tick();
    req_n = 8'hEF;
    tick();
    req_n = 8'hFF;
    tick();
    // New edge on line 4 in the same cycle its presentation is acked.
    ack   = 1'b1;
    req_n = 8'hEF;
    tick();
    ack   = 1'b0;
    req_n = 8'hFF;
    n_checks++;
    if (obs_hi !== {1'b0, 3'd0, 1'b0, 8'h10})
      $display("FAIL set_wins got=%h want=%h", obs_hi, {1'b0, 3'd0, 1'b0, 8'h10});
    else n_pass++;
    tick();
    n_checks++;
    if (obs_hi !== {1'b1, 3'd4, 1'b0, 8'h10})
      $display("FAIL set_wins_repres got=%h want=%h", obs_hi, {1'b1, 3'd4, 1'b0, 8'h10});
    else n_pass++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_n = 8'hFD;
    tick();
    tick();
    n_checks++;
    if (obs_hi !== {1'b1, 3'd1, 1'b0, 8'h02})
      $display("FAIL rst_mid_pre got=%h want=%h", obs_hi, {1'b1, 3'd1, 1'b0, 8'h02});
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (obs_hi !== {1'b0, 3'd0, 1'b1, 8'h00})
      $display("FAIL rst_mid_drop got=%h want=%h", obs_hi, {1'b0, 3'd0, 1'b1, 8'h00});
    else n_pass++;
    tick();
    n_checks++;
    if (obs_hi !== {1'b0, 3'd0, 1'b0, 8'h02})
      $display("FAIL rst_mid_repend got=%h want=%h", obs_hi, {1'b0, 3'd0, 1'b0, 8'h02});
    else n_pass++;
    tick();
    n_checks++;
    if (obs_hi !== {1'b1, 3'd1, 1'b0, 8'h02})
      $display("FAIL rst_mid_repres got=%h want=%h", obs_hi, {1'b1, 3'd1, 1'b0, 8'h02});
    else n_pass++;
    ack = 1'b1;
    tick();
    ack   = 1'b0;
    req_n = 8'hFF;
    tick();
  endtask

  task automatic test_ack_ignored();
    ack   = 1'b1;
    req_n = 8'hFE;
    tick();
    req_n = 8'hFF;
    n_checks++;
    if (obs_hi !== {1'b0, 3'd0, 1'b0, 8'h01})
      $display("FAIL ack_idle got=%h want=%h", obs_hi, {1'b0, 3'd0, 1'b0, 8'h01});
    else n_pass++;
    tick();
    n_checks++;
    if (obs_hi !== {1'b1, 3'd0, 1'b0, 8'h01})
      $display("FAIL ack_idle_present got=%h want=%h", obs_hi, {1'b1, 3'd0, 1'b0, 8'h01});
    else n_pass++;
    tick();
    ack = 1'b0;
    n_checks++;
    if (obs_hi !== {1'b0, 3'd0, 1'b1, 8'h00})
      $display("FAIL ack_idle_clear got=%h want=%h", obs_hi, {1'b0, 3'd0, 1'b1, 8'h00});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] flip;
    for (int c = 0; c < 800; c++) begin
      flip = '0;
      for (int i = 0; i < 8; i++) flip[i] = ($urandom_range(0, 5) == 0);
      req_n = req_n ^ flip;
      ack   = ($urandom_range(0, 2) == 0);
      e1    = ($urandom_range(0, 9) != 0);
      ne2   = ($urandom_range(0, 11) == 0);
      ne3   = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 149) == 0);
      tick();
      n_checks++;
      if (obs_hi !== exp_obs(0))
        $display("FAIL random_hi cyc=%0d got=%h want=%h", c, obs_hi, exp_obs(0));
      else n_pass++;
      n_checks++;
      if (obs_lo !== exp_obs(1))
        $display("FAIL random_lo cyc=%0d got=%h want=%h", c, obs_lo, exp_obs(1));
      else n_pass++;
    end
    reset = 1'b0; e1 = 1'b1; ne2 = 1'b0; ne3 = 1'b0; ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_lines();
    test_hold_stable();
    test_held_low();
    test_reset_mid();
    test_ack_ignored();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
